// File: rtl/voltage_calculator.sv
// Turns the latest ADC sample into three BCD digits (X.YZ volts) for the 7-segment displayer.
// A registered scale-to-centivolts multiply is followed by a 10-cycle sequential double-dabble.
module voltage_calculator #(
  parameter int ADC_W   = 8,
  parameter int VREF_CV = 330
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic             flag,
  output logic [3:0]       integer_data,
  output logic [3:0]       float1_data,
  output logic [3:0]       float2_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, MULT, CONV, DONE} state_t;

  state_t             state_reg, state_next;
  logic               busy_reg, done_reg;
  logic [ADC_W-1:0]   sample_reg;
  logic [ADC_W-1:0]   operand;
  logic [ADC_W+9:0]   prod_reg, prod_calc;
  logic [9:0]         cv_raw, cv;
  logic [21:0]        shift_reg, shift_next;
  logic [11:0]        bcd_adj;
  logic [3:0]         iter_reg;
  logic [3:0]         int_reg, f1_reg, f2_reg;

  // A sample arriving on the same edge as the request wins over the stored one.
  assign operand   = adc_valid ? adc_data : sample_reg;
  assign prod_calc = (ADC_W+10)'(operand) * (ADC_W+10)'(VREF_CV);

  assign cv_raw = prod_reg[ADC_W+9:ADC_W];
  assign cv     = (cv_raw > 10'd999) ? 10'd999 : cv_raw;

  // Add-3 correction on each BCD nibble before the left shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dabble
      assign bcd_adj[gi*4 +: 4] = (shift_reg[10+gi*4 +: 4] >= 4'd5)
                                  ? shift_reg[10+gi*4 +: 4] + 4'd3
                                  : shift_reg[10+gi*4 +: 4];
    end
  endgenerate

  assign shift_next = {bcd_adj, shift_reg[9:0]} << 1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (flag) state_next = MULT;
      MULT:    state_next = CONV;
      CONV:    if (iter_reg == 4'd9) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
      prod_reg   <= '0;
      shift_reg  <= '0;
      iter_reg   <= '0;
      int_reg    <= '0;
      f1_reg     <= '0;
      f2_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      if (adc_valid) sample_reg <= adc_data;
      done_reg <= (state_reg == DONE);
      case (state_reg)
        IDLE: if (flag) prod_reg <= prod_calc;
        MULT: begin
          shift_reg <= {12'd0, cv};
          iter_reg  <= '0;
        end
        CONV: begin
          shift_reg <= shift_next;
          iter_reg  <= iter_reg + 4'd1;
        end
        DONE: begin
          int_reg <= shift_reg[21:18];
          f1_reg  <= shift_reg[17:14];
          f2_reg  <= shift_reg[13:10];
        end
        default: ;
      endcase
    end
  end

  assign integer_data = int_reg;
  assign float1_data  = f1_reg;
  assign float2_data  = f2_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_voltage_calculator.sv
// Directed-vector bench for voltage_calculator: latency, digits, bypass, busy protection, back-to-back.
module tb_voltage_calculator;

  localparam int ADC_W   = 8;
  localparam int VREF_CV = 330;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             adc_valid = 1'b0;
  logic             flag = 1'b0;
  logic [3:0]       integer_data, float1_data, float2_data;
  logic             busy, done;

  int vectors = 0;
  int miscompares = 0;

  voltage_calculator #(.ADC_W(ADC_W), .VREF_CV(VREF_CV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .flag         (flag),
    .integer_data (integer_data),
    .float1_data  (float1_data),
    .float2_data  (float2_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    if (VREF_CV < 1 || VREF_CV > 999) $fatal(1, "VREF_CV out of range 1..999");
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_digits(input string tag, input int d2, input int d1, input int d0);
    check({tag, ".int"}, int'(integer_data), d2);
    check({tag, ".f1"},  int'(float1_data),  d1);
    check({tag, ".f2"},  int'(float2_data),  d0);
  endtask

  // Called right after the edge that sampled flag in IDLE; returns edges until done and busy-cycle count.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic convert(input string tag, input logic [7:0] d,
                         input int d2, input int d1, input int d0);
    int lat, bc;
    adc_data = d; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0; flag = 1'b1;
    tick();
    flag = 1'b0;
    wait_done(lat, bc);
    check({tag, ".latency"}, lat, 12);
    check({tag, ".busy_cycles"}, bc, 12);
    check_digits(tag, d2, d1, d0);
    $display("vector %s adc=%0d -> %0d.%0d%0d", tag, d, integer_data, float1_data, float2_data);
    tick();
    check({tag, ".done_width"}, int'(done), 0);
  endtask

  initial begin
    int lat, bc, pulses, last_done, gap_bad, dig_bad;

    // Reset state
    repeat (2) tick();
    check_digits("reset", 0, 0, 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    // Main function
    convert("adc255", 8'd255, 3, 2, 8);
    convert("adc128", 8'd128, 1, 6, 5);
    convert("adc1",   8'd1,   0, 0, 1);
    convert("adc0",   8'd0,   0, 0, 0);
    convert("adc255b", 8'd255, 3, 2, 8);

    // Bypass: same-edge sample beats stored 255
    adc_data = 8'd128; adc_valid = 1'b1; flag = 1'b1;
    tick();
    adc_valid = 1'b0; flag = 1'b0;
    wait_done(lat, bc);
    check("bypass.latency", lat, 12);
    check_digits("bypass", 1, 6, 5);
    $display("vector bypass adc=128 (stored 255) -> %0d.%0d%0d", integer_data, float1_data, float2_data);
    tick();

    // Busy protection: 100*330>>8 = 128
    adc_data = 8'd100; adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0; flag = 1'b1;
    tick();
    flag = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      flag = (c == 3 || c == 7);
      adc_valid = (c == 5);
      adc_data = (c == 5) ? 8'd0 : 8'd100;
      tick();
      if (c == 6) check_digits("busy_hold", 1, 6, 5);
      if (done) begin
        pulses++;
        check_digits("busy_prot", 1, 2, 8);
      end
    end
    flag = 1'b0; adc_valid = 1'b0;
    check("busy_prot.pulses", pulses, 1);
    $display("vector busy_protection pulses=%0d -> %0d.%0d%0d", pulses, integer_data, float1_data, float2_data);
    flag = 1'b1;
    tick();
    flag = 1'b0;
    wait_done(lat, bc);
    check("after_prot.latency", lat, 12);
    check_digits("after_prot", 0, 0, 0);
    $display("vector after_protection (stored 0) -> %0d.%0d%0d", integer_data, float1_data, float2_data);
    tick();

    // Continuous flag: pulses 13 cycles apart, each 2.57
    adc_data = 8'd200; adc_valid = 1'b1; flag = 1'b1;
    pulses = 0; last_done = -1; gap_bad = 0; dig_bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) begin
        if (last_done >= 0 && c - last_done != 13) gap_bad++;
        if (integer_data != 4'd2 || float1_data != 4'd5 || float2_data != 4'd7) dig_bad++;
        last_done = c;
        pulses++;
      end
    end
    flag = 1'b0; adc_valid = 1'b0;
    check("continuous.pulses", pulses, 3);
    check("continuous.gap_errors", gap_bad, 0);
    check("continuous.digit_errors", dig_bad, 0);
    $display("vector continuous adc=200 pulses=%0d last=%0d.%0d%0d", pulses, integer_data, float1_data, float2_data);
    lat = 0;
    while (busy && lat < 30) begin tick(); lat++; end
    check("continuous.drain", int'(busy), 0);
    tick();

    // Async reset mid-conversion (digits currently 2.57)
    adc_data = 8'd255; adc_valid = 1'b1; flag = 1'b1;
    tick();
    adc_valid = 1'b0; flag = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check_digits("midreset", 0, 0, 0);
    check("midreset.busy", int'(busy), 0);
    check("midreset.done", int'(done), 0);
    $display("vector midreset -> %0d.%0d%0d busy=%0d", integer_data, float1_data, float2_data, busy);
    tick();
    rst_n = 1'b1;
    tick();
    convert("post_reset", 8'd255, 3, 2, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voltage_calculator.md
Name: voltage_calculator

Overview:
- Converts the latest ADC sample into three BCD digits (X.YZ volts) that feed the 7-segment displayer's integer_data, float1_data and float2_data inputs.
- A conversion starts only when the displayer raises flag (its 0.5 s update request), so digits change only at display refresh points.
- Datapath: scale to centivolts with one registered multiply, then a fixed-latency sequential double-dabble binary-to-BCD conversion.

Parameters:
- ADC_W, 8, ADC sample width in bits.
- VREF_CV, 330, full-scale reference in centivolts. Legal range is 1..999; the bench asserts this at elaboration.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  asynchronous active-low reset
- adc_data  input  ADC_W  raw ADC sample
- adc_valid  input  1  adc_data is valid this cycle
- flag  input  1  update request from the displayer (level)
- integer_data  output  4  volts digit, BCD
- float1_data  output  4  tenths digit, BCD
- float2_data  output  4  hundredths digit, BCD
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when the digits update

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Sample register, product register, shift register and iteration counter cleared.
  - All digit outputs=0 (display shows 0.00); busy=0, done=0.
  - Assertion takes effect immediately, including mid-conversion.
  - Release is clean: the first edge with rst_n=1 evaluates normally.
- Sample capture:
  - On every edge with adc_valid=1, the sample register loads adc_data. This happens independently of state.
- States: IDLE, MULT, CONV, DONE.
- IDLE:
  - If flag=1, go to MULT and latch the conversion operand.
  - The operand is adc_data if adc_valid=1 on that edge (bypass); otherwise it is the sample register.
  - Otherwise stay in IDLE.
- MULT (1 cycle):
  - prod = operand * VREF_CV, ADC_W+10 bits, unsigned.
  - cv = prod >> ADC_W, truncated to 10 bits.
  - If cv > 999, saturate to 999.
  - Load the shift register with cv, clear the 12-bit BCD field, set iter=0, go to CONV.
- CONV (exactly 10 cycles):
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift the {BCD, bin} register left 1.
  - iter increments each cycle. After the 10th iteration (iter=9), go to DONE.
- DONE (1 cycle):
  - Register integer_data=BCD[11:8], float1_data=BCD[7:4], float2_data=BCD[3:0].
  - Set done=1 for exactly one cycle, then go to IDLE.
- Latency: if flag is sampled in IDLE at edge N, the new digits and done=1 appear after edge N+12. done clears after edge N+13.
- busy is 1 in MULT, CONV and DONE, and 0 in IDLE. It is registered with the state.
- Outputs hold their previous values during a conversion; there are no intermediate glitches.
- flag while busy: ignored, not queued.
- flag held high continuously: a new conversion starts on the first IDLE cycle after each DONE, one conversion every 13 cycles.
- adc_valid during a conversion: updates the sample register only. It never alters the operand already latched.
- All digit outputs stay within 0..9.

Test Plan:
- Reset: assert rst_n=0 mid-CONV -> immediately digits=0,0,0, busy=0, done=0. Release, then flag=1 -> a full conversion completes normally.
- adc_data=255 (adc_valid pulse), flag pulse -> after 12 edges digits=3,2,8, done high exactly 1 cycle, busy high for 12 cycles.
- adc_data=128 -> 1,6,5. adc_data=1 -> 0,0,1. adc_data=0 -> 0,0,0.
- Bypass: adc_valid=1 with adc_data=128 on the same edge as flag=1, while the sample register holds 255 -> result 1,6,5.
- Busy protection: flag pulses at cycles 3 and 7 of a conversion, and adc_data=0 with adc_valid during CONV -> only one done pulse, result from the original operand. A following flag then yields 0,0,0.
- Continuous flag=1 for 40 cycles with adc_data=200 -> done pulses exactly 13 cycles apart. Every result is 2,5,7 (200*330=66000>>8=257).
